// File: rtl/ffo_scheduler_if.sv
// Handshake bundle for ffo_scheduler: start/request load, grant offer, pass status.
// The abort input exists only when FFO_SCHED_ABORT_EN is defined.
interface ffo_scheduler_if #(
    parameter int N = 32
);
    localparam int W = $clog2(N);

    logic         start;
    logic [0:N-1] req_vec;
    logic         grant_valid;
    logic         grant_ready;
    logic [0:W-1] grant_idx;
    logic         busy;
    logic         done;
    logic [0:W]   grant_count;
`ifdef FFO_SCHED_ABORT_EN
    logic         abort;

    modport master (
        output start, req_vec, grant_ready, abort,
        input  grant_valid, grant_idx, busy, done, grant_count
    );

    modport slave (
        input  start, req_vec, grant_ready, abort,
        output grant_valid, grant_idx, busy, done, grant_count
    );
`else
    modport master (
        output start, req_vec, grant_ready,
        input  grant_valid, grant_idx, busy, done, grant_count
    );

    modport slave (
        input  start, req_vec, grant_ready,
        output grant_valid, grant_idx, busy, done, grant_count
    );
`endif
endinterface

// File: rtl/ffo_scheduler.sv
// Find-first-one grant scheduler: issues one index per cycle, leftmost first.
// Optional abort input enabled by defining FFO_SCHED_ABORT_EN.
module ffo_scheduler #(
    parameter int N = 32
) (
    input  logic        clk,
    input  logic        reset,
    ffo_scheduler_if.slave bus
);
    localparam int W = $clog2(N);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DONE
    } state_t;

    state_t       state_q, state_d;
    logic [0:N-1] pend_q, pend_d;
    logic [0:W]   cnt_q, cnt_d;
    logic [W-1:0] ffo;
    logic         hs;
    logic         abort_w;

`ifdef FFO_SCHED_ABORT_EN
    assign abort_w = bus.abort;
`else
    assign abort_w = 1'b0;
`endif

    assign hs = (state_q == ISSUE) && bus.grant_ready;

    // Leftmost pending bit; downward scan lets the lowest index win.
    always_comb begin
        ffo = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (pend_q[i]) ffo = i[W-1:0];
        end
    end

    // Next-state, pending and grant-count update.
    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    pend_d  = bus.req_vec;
                    cnt_d   = '0;
                    state_d = (|bus.req_vec) ? ISSUE : DONE;
                end
            end
            ISSUE: begin
                if (abort_w) begin
                    pend_d  = '0;
                    state_d = DONE;
                end else if (hs) begin
                    pend_d[ffo] = 1'b0;
                    cnt_d       = cnt_q + 1'b1;
                    if (pend_d == '0) state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers with synchronous reset taking priority.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            pend_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.grant_valid = (state_q == ISSUE);
    assign bus.grant_idx   = ffo;
    assign bus.busy        = (state_q != IDLE);
    assign bus.done        = (state_q == DONE);
    assign bus.grant_count = cnt_q;
endmodule

// File: tb/tb_ffo_scheduler.sv
// Scoreboard bench for ffo_scheduler with N=8.
// Abort scenario runs only when FFO_SCHED_ABORT_EN is defined.
module tb_ffo_scheduler;
    localparam int N = 8;

    logic clk;
    logic reset;
    logic abort_m;

    int n_chk;
    int n_fail;
    bit done_flag;
    int exp_idx_q[$];
    int exp_cnt_q[$];

    ffo_scheduler_if #(.N(N)) bus ();

    ffo_scheduler #(.N(N)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

`ifdef FFO_SCHED_ABORT_EN
    assign abort_m = bus.abort;
`else
    assign abort_m = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Output monitor: handshakes pop expected indices, done pops expected count.
    always @(negedge clk) begin
        if (!reset && !abort_m) begin
            if (bus.grant_valid && bus.grant_ready) begin
                if (exp_idx_q.size() > 0)
                    check("grant_idx", int'(bus.grant_idx), exp_idx_q.pop_front());
                else
                    check("grant_unexp", int'(bus.grant_valid), 0);
            end
        end
        if (!reset && bus.done) begin
            done_flag = 1'b1;
            if (exp_cnt_q.size() > 0)
                check("grant_count", int'(bus.grant_count), exp_cnt_q.pop_front());
            else
                check("done_unexp", int'(bus.done), 0);
        end
    end

    task automatic push_all(input logic [0:N-1] v);
        for (int i = 0; i < N; i++)
            if (v[i]) exp_idx_q.push_back(i);
    endtask

    task automatic start_pass(input logic [0:N-1] v);
        @(posedge clk);
        #1;
        done_flag   = 1'b0;
        bus.start   = 1'b1;
        bus.req_vec = v;
        @(posedge clk);
        #1;
        bus.start   = 1'b0;
        bus.req_vec = N'($urandom);
        check("first_valid", int'(bus.grant_valid), int'(v != '0));
        check("early_done", int'(bus.done), int'(v == '0));
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (!done_flag && n < 40) begin
            @(posedge clk);
            n++;
        end
        check("done_seen", int'(done_flag), 1);
        #1;
        check("idle_busy", int'(bus.busy), 0);
        check("idle_done", int'(bus.done), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_chk           = 0;
        n_fail          = 0;
        done_flag       = 1'b0;
        bus.start       = 1'b0;
        bus.req_vec     = '0;
        bus.grant_ready = 1'b0;
`ifdef FFO_SCHED_ABORT_EN
        bus.abort       = 1'b0;
`endif
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", int'(bus.grant_valid), 0);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_done", int'(bus.done), 0);
        check("rst_count", int'(bus.grant_count), 0);
        check("rst_idx", int'(bus.grant_idx), 0);
        reset = 1'b0;

        // Sparse pattern, ready tied high.
        bus.grant_ready = 1'b1;
        push_all(8'b0010_0101);
        exp_cnt_q.push_back(3);
        start_pass(8'b0010_0101);
        wait_done();

        // Empty request goes straight to done.
        exp_cnt_q.push_back(0);
        start_pass(8'h00);
        wait_done();

        // Back-pressure: index must hold while ready is low.
        bus.grant_ready = 1'b0;
        push_all(8'b1000_0001);
        exp_cnt_q.push_back(2);
        start_pass(8'b1000_0001);
        check("hold_idx", int'(bus.grant_idx), 0);
        repeat (2) begin
            @(posedge clk);
            #1;
            check("hold_valid", int'(bus.grant_valid), 1);
            check("hold_idx", int'(bus.grant_idx), 0);
        end
        bus.grant_ready = 1'b1;
        wait_done();

        // All bits set: count reaches N without wrap.
        push_all(8'hFF);
        exp_cnt_q.push_back(8);
        start_pass(8'hFF);
        wait_done();

        // Reset after the first grant abandons the pass.
        exp_idx_q.push_back(0);
        start_pass(8'hF0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("mid_rst_busy", int'(bus.busy), 0);
        check("mid_rst_valid", int'(bus.grant_valid), 0);
        check("mid_rst_done", int'(bus.done), 0);
        check("mid_rst_count", int'(bus.grant_count), 0);
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("mid_rst_idle", int'(bus.busy), 0);
        push_all(8'hF0);
        exp_cnt_q.push_back(4);
        start_pass(8'hF0);
        wait_done();

`ifdef FFO_SCHED_ABORT_EN
        // Abort collides with the second handshake; abort wins.
        exp_idx_q.push_back(4);
        exp_cnt_q.push_back(1);
        start_pass(8'h0F);
        @(posedge clk);
        #1;
        bus.abort = 1'b1;
        @(posedge clk);
        #1;
        bus.abort = 1'b0;
        check("abort_valid", int'(bus.grant_valid), 0);
        check("abort_done", int'(bus.done), 1);
        wait_done();
`endif

        repeat (2) @(posedge clk);
        check("idx_q_empty", exp_idx_q.size(), 0);
        check("cnt_q_empty", exp_cnt_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/ffo_scheduler.md
FFO_SCHEDULER -- requirements
Module: ffo_scheduler

Interface
REQ-001 The block SHALL have parameter N, default 32, giving the request vector width; it must be a power of two and at least 2.
REQ-002 The block SHALL have derived localparam W = $clog2(N), giving the grant index width.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port start, input, 1 bit: request to load req_vec and begin a pass.
REQ-006 The block SHALL have port req_vec, input, [0:N-1]: request bits; bit 0 is leftmost and highest priority.
REQ-007 The block SHALL have port grant_valid, output, 1 bit: grant_idx is offered.
REQ-008 The block SHALL have port grant_ready, input, 1 bit: consumer accepts the grant.
REQ-009 The block SHALL have port grant_idx, output, [0:W-1]: index of the leftmost pending bit.
REQ-010 The block SHALL have port busy, output, 1 bit: asserted while the FSM is not IDLE.
REQ-011 The block SHALL have port done, output, 1 bit: single-cycle end-of-pass pulse.
REQ-012 The block SHALL have port grant_count, output, [0:W]: number of grants accepted in the pass; valid while done=1.

Function
REQ-013 The FSM SHALL have the states IDLE, ISSUE and DONE.
REQ-014 In IDLE with start=1 and req_vec nonzero, the block SHALL load the pending register from req_vec, clear the count and go to ISSUE on the next edge.
REQ-015 In IDLE with start=1 and req_vec all zero, the block SHALL go directly to DONE with grant_count=0.
REQ-016 The block SHALL ignore start outside IDLE; req_vec is sampled only on the loading edge.
REQ-017 grant_valid SHALL be 1 exactly in ISSUE, and grant_idx SHALL be the find-first-one position of pending (leftmost set bit, index from 0).
REQ-018 The first grant_valid SHALL appear 1 cycle after the start edge.
REQ-019 A handshake SHALL occur when grant_valid and grant_ready are both 1.
REQ-020 On a handshake, the block SHALL clear pending[grant_idx] and increment the count by 1.
REQ-021 If that handshake leaves pending zero, the FSM SHALL go to DONE; otherwise it stays in ISSUE, presenting the next index in the next cycle.
REQ-022 While grant_ready=0 in ISSUE, grant_idx SHALL hold stable and pending SHALL be unchanged.
REQ-023 The block SHALL ignore grant_ready outside ISSUE.
REQ-024 The block SHALL issue at most one grant per cycle; a full pass with grant_ready tied high takes popcount(req_vec) ISSUE cycles plus 1 DONE cycle.
REQ-025 In DONE, the block SHALL assert done=1 for exactly one cycle, hold grant_count, and then go to IDLE.
REQ-026 A start in the DONE cycle SHALL be ignored.
REQ-027 grant_count SHALL be W+1 bits wide, so that N grants (all bits set) fit without wrap.

Reset
REQ-028 A synchronous reset SHALL put the FSM in IDLE and clear pending and the count, with grant_valid=0, busy=0, done=0, grant_count=0 and grant_idx=0.
REQ-029 Reset mid-pass SHALL abandon the pass without asserting done, and reset SHALL take priority over start and over a handshake.

Configuration
REQ-030 With macro FFO_SCHED_ABORT_EN defined, the block SHALL add an input port abort (1 bit).
REQ-031 With FFO_SCHED_ABORT_EN defined, abort=1 in ISSUE SHALL clear pending and go to DONE on the next edge, with grant_count equal to the grants accepted before the abort.
REQ-032 With FFO_SCHED_ABORT_EN defined, when abort and a handshake occur in the same cycle, abort SHALL win and that grant SHALL not be counted.
REQ-033 With FFO_SCHED_ABORT_EN defined, the block SHALL ignore abort outside ISSUE.
REQ-034 Without FFO_SCHED_ABORT_EN, the abort port and its logic SHALL be absent, and a pass SHALL end only when pending is empty or on reset.

Verification (N=8)
REQ-035 The bench SHALL cover: start, req_vec=8'b0010_0101, grant_ready=1 -> grant_idx 2, 5, 7 on consecutive cycles, then done=1 with grant_count=3.
REQ-036 The bench SHALL cover: start, req_vec=0 -> done pulse 1 cycle after start, grant_count=0, grant_valid never asserted.
REQ-037 The bench SHALL cover: req_vec=8'b1000_0001, grant_ready low for 3 cycles -> grant_idx holds 0 and valid holds; then 0 and 7 are accepted, grant_count=2.
REQ-038 The bench SHALL cover: req_vec=8'hFF, grant_ready=1 -> 8 grants, indices 0..7, and grant_count=8 with no wrap.
REQ-039 The bench SHALL cover: reset asserted after the 1st grant of 8'hF0 -> next cycle IDLE, busy=0, no done; a new start then grants from index 0.
REQ-040 The bench SHALL cover, with FFO_SCHED_ABORT_EN defined: abort with a simultaneous handshake on the 2nd grant of 8'h0F -> done with grant_count=1.
